// File: rtl/gate_tester.sv
// rtl/gate_tester.sv - stimulus driver and truth-table checker for a 2-input gate
// Sweeps {a,b} = 00..11 for PASSES sweeps, waits SETTLE_CYCLES, then samples dut_c.
module gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH         = 4'b0001,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] drv_q, drv_d;
    logic [7:0] err_q, err_d;
    logic       fv_q, fv_d;
    logic [1:0] fvec_q, fvec_d;
    logic       pass_q, pass_d;

    logic       exp_c;
    logic       mismatch;
    logic [7:0] err_next;

    // Anything other than a clean 0/1 on dut_c is treated as a mismatch.
    always_comb begin
        exp_c    = TRUTH[vec_q];
        mismatch = 1'b1;
        case (dut_c)
            1'b0:    mismatch = exp_c;
            1'b1:    mismatch = ~exp_c;
            default: mismatch = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pcnt_d   = pcnt_q;
        settle_d = settle_q;
        drv_d    = drv_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        err_next = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = 2'd0;
                    pcnt_d  = 8'd0;
                    err_d   = 8'd0;
                    fv_d    = 1'b0;
                    fvec_d  = 2'd0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                drv_d    = vec_q;
                settle_d = SETTLE_LD;
                state_d  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q <= 4'd1) begin
                    settle_d = 4'd0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_next = err_q + 8'd1;
                    end
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                err_d = err_next;
                if (vec_q == 2'd3 && pcnt_q == LAST_PASS) begin
                    state_d = S_DONE;
                    pass_d  = (err_next == 8'd0);
                end else begin
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        pcnt_d = pcnt_q + 8'd1;
                    end
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 2'd0;
            pcnt_q   <= 8'd0;
            settle_q <= 4'd0;
            drv_q    <= 2'd0;
            err_q    <= 8'd0;
            fv_q     <= 1'b0;
            fvec_q   <= 2'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            pcnt_q   <= pcnt_d;
            settle_q <= settle_d;
            drv_q    <= drv_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fvec_q   <= fvec_d;
            pass_q   <= pass_d;
        end
    end

    assign drv_a      = drv_q[1];
    assign drv_b      = drv_q[0];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_tester.sv
// tb/tb_gate_tester.sv - scoreboard bench for gate_tester
// Stimulus pushes timed expectations and run results; one monitor compares them.
module tb_gate_tester;

    localparam int SIG_DRV  = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_ERR  = 2;
    localparam int SIG_DONE = 3;
    localparam int SIG_FV   = 4;
    localparam int SIG_FVEC = 5;
    localparam int SIG_PASS = 6;
    localparam int LIMIT    = 4000;

    typedef struct {
        int    cyc;
        int    sig;
        int    exp;
        string name;
    } chk_t;

    typedef struct {
        int done_cyc;
        int err;
        int fv;
        int fvec;
        int pass;
    } run_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, start, start2;
    int         mode;
    logic       dut_c;
    logic       drv_a, drv_b, busy, done, pass, fail_valid;
    logic [7:0] err_count;
    logic [1:0] fail_vec;
    logic       drv_a2, drv_b2, busy2, done2, pass2, fail_valid2;
    logic [7:0] err_count2;
    logic [1:0] fail_vec2;
    logic       end_req = 1'b0;

    chk_t chkq[$];
    run_t q1[$];
    run_t q2[$];
    int   total = 0;
    int   bad   = 0;

    // 0: NOR (correct), 1: stuck-at-0, 2: OR, 3: stuck-at-1
    always_comb begin
        dut_c = 1'b0;
        case (mode)
            0:       dut_c = ~(drv_a | drv_b);
            1:       dut_c = 1'b0;
            2:       dut_c = drv_a | drv_b;
            default: dut_c = 1'b1;
        endcase
    end

    gate_tester #(.SETTLE_CYCLES(2), .TRUTH(4'b0001), .PASSES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .drv_a(drv_a), .drv_b(drv_b), .dut_c(dut_c),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    gate_tester #(.SETTLE_CYCLES(0), .TRUTH(4'b0001), .PASSES(100)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .drv_a(drv_a2), .drv_b(drv_b2), .dut_c(1'b1),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .fail_valid(fail_valid2), .fail_vec(fail_vec2)
    );

    function automatic int sample(input int sig);
        case (sig)
            SIG_DRV:  return int'({drv_a, drv_b});
            SIG_BUSY: return int'(busy);
            SIG_ERR:  return int'(err_count);
            SIG_DONE: return int'(done);
            SIG_FV:   return int'(fail_valid);
            SIG_FVEC: return int'(fail_vec);
            default:  return int'(pass);
        endcase
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_up();
        foreach (chkq[i]) begin
            total++; bad++;
            $display("FAIL %s: check at cyc %0d never reached", chkq[i].name, chkq[i].cyc);
        end
        foreach (q1[i]) begin
            total++; bad++;
            $display("FAIL dut1_done: expected at cyc %0d, never seen", q1[i].done_cyc);
        end
        foreach (q2[i]) begin
            total++; bad++;
            $display("FAIL dut2_done: expected at cyc %0d, never seen", q2[i].done_cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    always @(negedge clk) begin
        run_t r;
        for (int i = chkq.size() - 1; i >= 0; i--) begin
            if (chkq[i].cyc == cyc) begin
                cmp(chkq[i].name, sample(chkq[i].sig), chkq[i].exp);
                chkq.delete(i);
            end
        end
        if (done) begin
            if (q1.size() == 0) begin
                cmp("dut1_unexpected_done", 1, 0);
            end else begin
                r = q1.pop_front();
                cmp("dut1_done_cycle", cyc, r.done_cyc);
                cmp("dut1_err_count", int'(err_count), r.err);
                cmp("dut1_fail_valid", int'(fail_valid), r.fv);
                cmp("dut1_fail_vec", int'(fail_vec), r.fvec);
                cmp("dut1_pass", int'(pass), r.pass);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                cmp("dut2_unexpected_done", 1, 0);
            end else begin
                r = q2.pop_front();
                cmp("dut2_done_cycle", cyc, r.done_cyc);
                cmp("dut2_err_count", int'(err_count2), r.err);
                cmp("dut2_fail_valid", int'(fail_valid2), r.fv);
                cmp("dut2_fail_vec", int'(fail_vec2), r.fvec);
                cmp("dut2_pass", int'(pass2), r.pass);
            end
        end
        if (cyc > LIMIT) begin
            cmp("watchdog", cyc, LIMIT);
            finish_up();
        end else if (end_req) begin
            finish_up();
        end
    end

    task automatic push_chk(input int c, input int sig, input int exp, input string nm);
        chk_t k;
        k.cyc = c; k.sig = sig; k.exp = exp; k.name = nm;
        chkq.push_back(k);
    endtask

    task automatic push_run(input int id, input int dc, input int err, input int fv,
                            input int fvec, input int ps);
        run_t r;
        r.done_cyc = dc; r.err = err; r.fv = fv; r.fvec = fvec; r.pass = ps;
        if (id == 1) q1.push_back(r);
        else         q2.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        @(negedge clk);
        push_chk(cyc + 1, SIG_DRV,  0, "rst_drv");
        push_chk(cyc + 1, SIG_BUSY, 0, "rst_busy");
        push_chk(cyc + 1, SIG_ERR,  0, "rst_err");
        push_chk(cyc + 1, SIG_DONE, 0, "rst_done");
        push_chk(cyc + 1, SIG_FV,   0, "rst_fail_valid");
        push_chk(cyc + 1, SIG_FVEC, 0, "rst_fail_vec");
        push_chk(cyc + 1, SIG_PASS, 0, "rst_pass");
        tick(2); rst = 1'b0; tick(1);

        // Correct NOR: sweep 00,01,10,11 with done in cycle 17
        mode = 0; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) push_chk(t0 + 2 + 4 * k, SIG_DRV, k, "nor_drv_seq");
        push_chk(t0 + 1,  SIG_BUSY, 1, "nor_busy_start");
        push_chk(t0 + 17, SIG_BUSY, 1, "nor_busy_done");
        push_chk(t0 + 18, SIG_BUSY, 0, "nor_busy_idle");
        push_chk(t0 + 18, SIG_DONE, 0, "nor_done_pulse");
        push_chk(t0 + 20, SIG_DRV,  3, "nor_drv_hold");
        tick(1); start = 1'b0; tick(22);

        // Stuck-at-0: only vector 00 mismatches
        mode = 1; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 1, 1, 0, 0);
        push_chk(t0 + 20, SIG_PASS, 0, "st0_pass_hold");
        push_chk(t0 + 20, SIG_FV,   1, "st0_fv_hold");
        tick(1); start = 1'b0; tick(22);

        // OR gate: every vector mismatches; start pulses while busy are ignored
        mode = 2; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 4, 1, 0, 0);
        tick(1); start = 1'b0; tick(5);
        start = 1'b1; tick(1); start = 1'b0; tick(5);
        start = 1'b1; tick(1); start = 1'b0; tick(14);

        // Stuck-at-1: first mismatch at 01; results from the OR run cleared on start
        mode = 3; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 3, 1, 1, 0);
        push_chk(t0 + 1, SIG_ERR, 0, "st1_err_cleared");
        push_chk(t0 + 1, SIG_FV,  0, "st1_fv_cleared");
        tick(1); start = 1'b0; tick(22);

        // Reset during SETTLE of vector 10 aborts the run
        mode = 1; t0 = cyc; start = 1'b1;
        push_chk(t0 + 9,  SIG_ERR,  1, "abort_err_before");
        push_chk(t0 + 10, SIG_DRV,  2, "abort_drv_before");
        push_chk(t0 + 11, SIG_BUSY, 0, "abort_busy");
        push_chk(t0 + 11, SIG_DRV,  0, "abort_drv");
        push_chk(t0 + 11, SIG_ERR,  0, "abort_err");
        push_chk(t0 + 11, SIG_FV,   0, "abort_fv");
        tick(1); start = 1'b0; tick(9);
        rst = 1'b1; tick(1); rst = 1'b0; tick(3);
        mode = 0; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 0, 0, 0, 1);
        push_chk(t0 + 2, SIG_DRV, 0, "replay_drv0");
        push_chk(t0 + 6, SIG_DRV, 1, "replay_drv1");
        tick(1); start = 1'b0; tick(22);

        // start held 40 cycles: back-to-back runs with one IDLE cycle between
        // (the third run is accepted in cycle 36 while start is still high)
        mode = 0; t0 = cyc; start = 1'b1;
        push_run(1, t0 + 17, 0, 0, 0, 1);
        push_run(1, t0 + 35, 0, 0, 0, 1);
        push_run(1, t0 + 53, 0, 0, 0, 1);
        push_chk(t0 + 18, SIG_BUSY, 0, "held_idle1");
        push_chk(t0 + 19, SIG_BUSY, 1, "held_restart");
        push_chk(t0 + 36, SIG_BUSY, 0, "held_idle2");
        tick(40); start = 1'b0; tick(20);

        // 100 sweeps, no settle, stuck-at-1: 300 mismatches saturate at 255
        t0 = cyc; start2 = 1'b1;
        push_run(2, t0 + 801, 255, 1, 1, 0);
        tick(1); start2 = 1'b0; tick(810);

        end_req = 1'b1;
        tick(3);
    end

endmodule
